pwm_deadtime: RTL and testbench

- Gate-drive stage directly downstream of the three-phase SVM block.
- Consumes the raw registered phase PWM levels (pwmA/B/C) and produces complementary high-side/low-side gate signals per phase.
- Inserts a programmable dead time at every commutation, so the two switches of a leg are never on together.
- A sticky fault latch forces all gates off.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_deadtime_leg.sv | 130 +++++++++++++
 rtl/pwm_deadtime.sv | 84 ++++++++
 tb/tb_pwm_deadtime.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the gate-drive dead-time slice.
package pwm_pkg;

  typedef enum logic [1:0] {
    OFF,
    DEAD,
    HI_ON,
    LO_ON
  } dt_state_t;

  localparam int unsigned DT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/pwm_deadtime_leg.sv
// One half-bridge leg: dead-time FSM with registered complementary gates.
// Optional minimum on-time hold is enabled by DEADTIME_MIN_ON_EN.
module pwm_deadtime_leg
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
`ifdef DEADTIME_MIN_ON_EN
  ,
  parameter int unsigned MIN_ON = 4
`endif
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                force_off,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  output logic                hi,
  output logic                lo,
  output logic                busy
);

  dt_state_t           state_q, state_d;
  logic                target_q, target_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DT_WIDTH-1:0] dt_load;
  logic                hi_q, hi_d;
  logic                lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                hold;

  // A zero dead time is promoted to one cycle of both-off.
  assign dt_load = (dead_cycles == '0) ? '0 : dead_cycles - DT_WIDTH'(1);

`ifdef DEADTIME_MIN_ON_EN
  localparam int unsigned MON_W = $clog2(MIN_ON + 1);
  logic [MON_W-1:0] mon_q, mon_d;

  // Edges arriving while the hold runs are simply re-evaluated once it expires.
  assign hold = (mon_q != '0);

  always_comb begin
    mon_d = mon_q;
    if (state_q == DEAD && (state_d == HI_ON || state_d == LO_ON)) begin
      mon_d = MON_W'(MIN_ON - 1);
    end else if (mon_q != '0) begin
      mon_d = mon_q - MON_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mon_q <= '0;
    end else begin
      mon_q <= mon_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= OFF;
      target_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (force_off) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d  = DEAD;
          target_d = raw;
          cnt_d    = dt_load;
        end
        DEAD: begin
          // Target follows raw, but the counter is never restarted.
          target_d = raw;
          if (cnt_q == '0) begin
            state_d = raw ? HI_ON : LO_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        HI_ON, LO_ON: begin
          if (!hold && (raw != target_q)) begin
            state_d  = DEAD;
            target_d = raw;
            cnt_d    = dt_load;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Gate levels are decoded from the next state so they land in flops.
  always_comb begin
    hi_d   = 1'b0;
    lo_d   = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      HI_ON:   hi_d   = 1'b1;
      LO_ON:   lo_d   = 1'b1;
      DEAD:    busy_d = 1'b1;
      default: ;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Three-phase gate driver with dead-time insertion and sticky fault latch.
// Define DEADTIME_MIN_ON_EN to add a per-phase minimum on-time hold.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
`ifdef DEADTIME_MIN_ON_EN
  ,
  parameter int unsigned MIN_ON = 4
`endif
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                enable,
  input  logic                pwm_a,
  input  logic                pwm_b,
  input  logic                pwm_c,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                ga_hi,
  output logic                ga_lo,
  output logic                gb_hi,
  output logic                gb_lo,
  output logic                gc_hi,
  output logic                gc_lo,
  output logic                fault_latched,
  output logic [2:0]          dt_busy
);

  logic       fault_latched_q, fault_latched_d;
  logic       force_off;
  logic [2:0] raw_v, hi_v, lo_v, busy_v;

  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end

  // The raw fault input kills the gates on the same edge that latches it.
  assign force_off = ~enable | fault | fault_latched_q;
  assign raw_v     = {pwm_c, pwm_b, pwm_a};

  for (genvar i = 0; i < 3; i++) begin : g_leg
    pwm_deadtime_leg #(
      .DT_WIDTH(DT_WIDTH)
`ifdef DEADTIME_MIN_ON_EN
      ,
      .MIN_ON(MIN_ON)
`endif
    ) u_leg (
      .clk        (clk),
      .rstb       (rstb),
      .force_off  (force_off),
      .raw        (raw_v[i]),
      .dead_cycles(dead_cycles),
      .hi         (hi_v[i]),
      .lo         (lo_v[i]),
      .busy       (busy_v[i])
    );
  end

  assign ga_hi         = hi_v[0];
  assign ga_lo         = lo_v[0];
  assign gb_hi         = hi_v[1];
  assign gb_lo         = lo_v[1];
  assign gc_hi         = hi_v[2];
  assign gc_lo         = lo_v[2];
  assign fault_latched = fault_latched_q;
  assign dt_busy       = busy_v;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime with a continuous no-overlap monitor.
module tb_pwm_deadtime;

  logic       clk;
  logic       rstb;
  logic       enable;
  logic       pwm_a, pwm_b, pwm_c;
  logic [7:0] dead_cycles;
  logic       fault, fault_clr;
  logic       ga_hi, ga_lo, gb_hi, gb_lo, gc_hi, gc_lo;
  logic       fault_latched;
  logic [2:0] dt_busy;
  logic [5:0] gates;
  logic       mon_en;
  int         checks;
  int         failures;

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .enable       (enable),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .pwm_c        (pwm_c),
    .dead_cycles  (dead_cycles),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .ga_hi        (ga_hi),
    .ga_lo        (ga_lo),
    .gb_hi        (gb_hi),
    .gb_lo        (gb_lo),
    .gc_hi        (gc_hi),
    .gc_lo        (gc_lo),
    .fault_latched(fault_latched),
    .dt_busy      (dt_busy)
  );

  assign gates = {ga_hi, ga_lo, gb_hi, gb_lo, gc_hi, gc_lo};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("no_overlap", 32'({ga_hi & ga_lo, gb_hi & gb_lo, gc_hi & gc_lo}), 32'd0);
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    mon_en      = 1'b0;
    rstb        = 1'b0;
    enable      = 1'b0;
    pwm_a       = 1'b0;
    pwm_b       = 1'b0;
    pwm_c       = 1'b0;
    dead_cycles = 8'd3;
    fault       = 1'b0;
    fault_clr   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_gates", 32'(gates), 32'h00);
    check("rst_fault", 32'(fault_latched), 32'd0);
    check("rst_busy", 32'(dt_busy), 32'd0);
    rstb = 1'b1;
    tick();
    check("idle_disabled", 32'(gates), 32'h00);
    mon_en = 1'b1;

    // Power-up: D=3, A high, B/C low
    enable = 1'b1;
    pwm_a  = 1'b1;
    tick();
    check("t1_e0_gates", 32'(gates), 32'h00);
    check("t1_e0_busy", 32'(dt_busy), 32'h7);
    tick();
    tick();
    check("t1_e2_gates", 32'(gates), 32'h00);
    tick();
    check("t1_e3_gates", 32'(gates), 32'b100101);
    check("t1_e3_busy", 32'(dt_busy), 32'd0);

    // A 1->0 with D=5
    dead_cycles = 8'd5;
    pwm_a       = 1'b0;
    tick();
    check("t2_k_gates", 32'(gates), 32'b000101);
    check("t2_k_busy", 32'(dt_busy), 32'b001);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t2_dead_gates", 32'(gates), 32'b000101);
      check("t2_dead_busy", 32'(dt_busy), 32'b001);
    end
    tick();
    check("t2_k5_gates", 32'(gates), 32'b010101);
    check("t2_k5_busy", 32'(dt_busy), 32'd0);

    // dead_cycles=0 behaves as one cycle
    dead_cycles = 8'd0;
    pwm_b       = 1'b1;
    tick();
    check("t3_off", 32'(gates), 32'b010001);
    check("t3_busy", 32'(dt_busy), 32'b010);
    tick();
    check("t3_on", 32'(gates), 32'b011001);
    for (int i = 0; i < 4; i++) begin
      pwm_b = ~pwm_b;
      tick();
      check("t3_tog_off", 32'(gates), 32'b010001);
      tick();
      check("t3_tog_on", 32'(gates), pwm_b ? 32'b011001 : 32'b010101);
      repeat (8) tick();
    end

    // C to high side with D=4, then a one-cycle glitch
    dead_cycles = 8'd4;
    pwm_c       = 1'b1;
    tick();
    check("t4_start", 32'(gates), 32'b011000);
    check("t4_busy", 32'(dt_busy), 32'b100);
    repeat (3) tick();
    check("t4_k3", 32'(gates), 32'b011000);
    tick();
    check("t4_on", 32'(gates), 32'b011010);
    pwm_c = 1'b0;
    tick();
    check("t4_glitch_k", 32'(gates), 32'b011000);
    pwm_c       = 1'b1;
    dead_cycles = 8'd0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t4_glitch_dead", 32'(gates), 32'b011000);
    end
    tick();
    check("t4_glitch_back", 32'(gates), 32'b011010);
    dead_cycles = 8'd3;

    // Fault latch, ignored clear, fault-wins, clear, restart
    fault = 1'b1;
    tick();
    check("t5_fault_gates", 32'(gates), 32'h00);
    check("t5_fault_latch", 32'(fault_latched), 32'd1);
    fault = 1'b0;
    tick();
    check("t5_sticky", 32'(fault_latched), 32'd1);
    check("t5_sticky_gates", 32'(gates), 32'h00);
    fault     = 1'b1;
    fault_clr = 1'b1;
    tick();
    check("t5_fault_wins", 32'(fault_latched), 32'd1);
    fault = 1'b0;
    tick();
    check("t5_cleared", 32'(fault_latched), 32'd0);
    check("t5_clr_gates", 32'(gates), 32'h00);
    fault_clr = 1'b0;
    tick();
    check("t5_restart_busy", 32'(dt_busy), 32'h7);
    tick();
    tick();
    check("t5_restart_dead", 32'(gates), 32'h00);
    tick();
    check("t5_restart_on", 32'(gates), 32'b011010);

    // enable=0 forces off without touching the latch
    enable = 1'b0;
    tick();
    check("t6_dis_gates", 32'(gates), 32'h00);
    check("t6_dis_busy", 32'(dt_busy), 32'd0);
    check("t6_dis_latch", 32'(fault_latched), 32'd0);
    enable = 1'b1;
    repeat (3) tick();
    check("t6_en_dead", 32'(gates), 32'h00);
    tick();
    check("t6_en_on", 32'(gates), 32'b011010);

    // Asynchronous reset mid-cycle
    #3;
    rstb = 1'b0;
    #1;
    check("t7_async_gates", 32'(gates), 32'h00);
    check("t7_async_busy", 32'(dt_busy), 32'd0);
    tick();
    rstb = 1'b1;
    tick();

    // Random run; overlap monitor is the check
    for (int i = 0; i < 400; i++) begin
      pwm_a       = 1'($urandom_range(0, 1));
      pwm_b       = 1'($urandom_range(0, 1));
      pwm_c       = 1'($urandom_range(0, 1));
      dead_cycles = 8'($urandom_range(0, 3));
      fault       = ($urandom_range(0, 49) == 0);
      fault_clr   = ($urandom_range(0, 9) == 0);
      enable      = ($urandom_range(0, 39) != 0);
      tick();
    end

    mon_en = 1'b0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
